data_access_unit: RTL and testbench
===================================

# data_access_unit

Request-side initiator for `data_memory`. It takes byte and 16-bit load/store requests from the processor datapath through a valid/ready handshake and sequences them into single-byte accesses on the memory port. It captures `data_out` with the memory's one-cycle read latency and returns one response pulse per request. It sits between the core's load/store stage and `data_memory`.

## Interface
- `ADDR_W`, 16, width of the request address and of `mem_addr`.

- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_word`  in  1  1 = 16-bit access (two bytes, little-endian), 0 = byte access.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  16  store data; only bits [7:0] are used for byte stores.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  16  load result; 0 for stores.
- `resp_err`  out  1  readback mismatch, qualified by `resp_valid`.
- `mem_write_en`  out  1  drives `data_memory` write_en.
- `mem_addr`  out  ADDR_W  drives `data_memory` addr.
- `mem_data_in`  out  16  drives `data_memory` data_in; upper byte always 0.
- `mem_data_out`  in  8  from `data_memory` data_out.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_CAP, VFY_ADDR, VFY_CAP, RESP.
- IDLE: `req_ready`=1. When `req_valid && req_ready`, the unit latches addr, wdata, write and word, clears the byte index and error flag, and goes to WR (store) or RD_ADDR (load).
- WR: `mem_write_en`=1, `mem_addr`=base+idx, `mem_data_in`={8'h00, byte[idx]}. byte[0]=wdata[7:0], byte[1]=wdata[15:8]. Next state is VFY_ADDR when the macro is enabled. Otherwise: if word and idx=0, idx=1 and stay in WR; else go to RESP.
- RD_ADDR: `mem_write_en`=0, `mem_addr`=base+idx. Go to RD_CAP.
- RD_CAP: hold `mem_addr` and capture `mem_data_out` into rdata byte[idx] at the end of the cycle. If word and idx=0, set idx=1 and go to RD_ADDR; else go to RESP.
- VFY_ADDR and VFY_CAP: same as RD_ADDR and RD_CAP, except the captured byte is compared with byte[idx]. A mismatch sets the sticky error flag. Then the unit continues with the next WR byte or goes to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0. Go to IDLE.
- Load data: byte load gives `resp_rdata`={8'h00, b0}; word load gives {b1, b0}. Store responses give `resp_rdata`=0.
- Address arithmetic is modulo 2^ADDR_W, so base 16'hFFFF plus 1 wraps to 16'h0000.
- When `mem_write_en`=0, `mem_data_in`=0. `mem_addr` holds its last value outside active states.
- `req_*` inputs are ignored in every state except IDLE. `resp_valid` has no backpressure.

## Timing
- Reset (`rst_n`=0 at an edge) forces state IDLE and sets all outputs to 0. This includes `req_ready`=0, `mem_addr`=0, `resp_rdata`=0 and `resp_err`=0.
- `req_ready` rises in the first cycle after `rst_n` is sampled high.
- Reset mid-operation: the transaction is abandoned and no response is issued. `mem_write_en` is 0 from the first reset cycle onward.
- Let cycle 0 be the accept cycle. Latencies without the macro:
  - byte store: WR in cycle 1, `resp_valid` in cycle 2.
  - word store: WR in cycles 1 and 2, `resp_valid` in cycle 3.
  - byte load: RD_ADDR in cycle 1, RD_CAP in cycle 2, `resp_valid` in cycle 3.
  - word load: `resp_valid` in cycle 5.
- The next request can be accepted in the cycle after RESP. Maximum throughput is one request per (latency+1) cycles.

## Configuration
- `DATA_ACCESS_READBACK_EN` defined: every written byte is immediately read back at the same address (VFY_ADDR, then VFY_CAP), and `resp_err` reports any mismatch. Store latency with the macro: byte store `resp_valid` in cycle 4, word store `resp_valid` in cycle 7. Load latency is unchanged.
- `DATA_ACCESS_READBACK_EN` undefined: the VFY states are not built and `resp_err` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release -> all outputs 0 during reset; `req_ready`=1 in the first cycle after release.
- Byte stores then loads: store 25@2, 50@5, 250@10, then load 2, 5, 10 -> `resp_rdata`=25, 50, 250; each `mem_data_in` upper byte is 0.
- Word store/load: store 16'hBEEF@16'h0020, then word load at 16'h0020 -> writes 8'hEF@0x20 and 8'hBE@0x21; `resp_rdata`=16'hBEEF; response in cycle 5 after accept.
- Wrap: word store 16'h1234@16'hFFFF -> byte 8'h34 written at 16'hFFFF and 8'h12 at 16'h0000; word load from 16'hFFFF returns 16'h1234.
- Reset mid-operation: assert `rst_n`=0 during RD_CAP of a word load -> no `resp_valid`; `req_ready`=1 one cycle after release; a following byte load at addr 2 returns 25.
- Macro on: force the memory model to corrupt address 7, then byte store 8'h55@7 -> `resp_valid` with `resp_err`=1 in cycle 4. Byte store to address 8 -> `resp_err`=0.

Source files
------------

// File: rtl/data_access_unit.sv
// Sequences byte/16-bit load-store requests into single-byte data_memory accesses.
// Optional write readback verification is built when DATA_ACCESS_READBACK_EN is defined.
module data_access_unit #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_word,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   output logic [15:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data_in,
   input  logic [7:0]        mem_data_out
);

   typedef enum logic [2:0] {
      IDLE, WR, RD_ADDR, RD_CAP, VFY_ADDR, VFY_CAP, RESP
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              write_q, write_d;
   logic              word_q, word_d;
   logic              idx_q, idx_d;
   logic              err_q, err_d;

   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [15:0]       resp_rdata_q, resp_rdata_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_data_in_q, mem_data_in_d;

   function automatic logic [7:0] byte_sel(input logic [15:0] data, input logic idx);
      return idx ? data[15:8] : data[7:0];
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and transaction context
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      write_d = write_q;
      word_d  = word_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               base_d  = req_addr;
               wdata_d = req_wdata;
               write_d = req_write;
               word_d  = req_word;
               idx_d   = 1'b0;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = req_write ? WR : RD_ADDR;
            end
         end
         WR: begin
`ifdef DATA_ACCESS_READBACK_EN
            state_d = VFY_ADDR;
`else
            if (word_q && !idx_q) idx_d = 1'b1;
            else                  state_d = RESP;
`endif
         end
         RD_ADDR: state_d = RD_CAP;
         RD_CAP: begin
            if (idx_q) rdata_d[15:8] = mem_data_out;
            else       rdata_d[7:0]  = mem_data_out;
            if (word_q && !idx_q) begin
               idx_d   = 1'b1;
               state_d = RD_ADDR;
            end else begin
               state_d = RESP;
            end
         end
`ifdef DATA_ACCESS_READBACK_EN
         VFY_ADDR: state_d = VFY_CAP;
         VFY_CAP: begin
            if (mem_data_out != byte_sel(wdata_q, idx_q)) err_d = 1'b1;
            if (word_q && !idx_q) begin
               idx_d   = 1'b1;
               state_d = WR;
            end else begin
               state_d = RESP;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the upcoming state so they align with it
   always_comb begin
      req_ready_d    = (state_d == IDLE);
      resp_valid_d   = (state_d == RESP);
      mem_write_en_d = (state_d == WR);
      mem_addr_d     = mem_addr_q;
      if (state_d inside {WR, RD_ADDR, RD_CAP, VFY_ADDR, VFY_CAP})
         mem_addr_d = base_d + ADDR_W'(idx_d);
      mem_data_in_d  = mem_write_en_d ? {8'h00, byte_sel(wdata_d, idx_d)} : 16'h0000;
      resp_rdata_d   = '0;
      if (resp_valid_d && !write_d)
         resp_rdata_d = word_d ? rdata_d : {8'h00, rdata_d[7:0]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q         <= '0;
         wdata_q        <= '0;
         rdata_q        <= '0;
         write_q        <= 1'b0;
         word_q         <= 1'b0;
         idx_q          <= 1'b0;
         err_q          <= 1'b0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         mem_write_en_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_in_q  <= '0;
      end else begin
         base_q         <= base_d;
         wdata_q        <= wdata_d;
         rdata_q        <= rdata_d;
         write_q        <= write_d;
         word_q         <= word_d;
         idx_q          <= idx_d;
         err_q          <= err_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         mem_write_en_q <= mem_write_en_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_in_q  <= mem_data_in_d;
      end
   end

`ifdef DATA_ACCESS_READBACK_EN
   logic resp_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) resp_err_q <= 1'b0;
      else        resp_err_q <= (state_d == RESP) && err_d;
   end

   assign resp_err = resp_err_q;
`else
   assign resp_err = 1'b0;
`endif

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_rdata   = resp_rdata_q;
   assign mem_write_en = mem_write_en_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_in_q;

endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit with a byte-array memory model and a reference memory.
module tb_data_access_unit;
   localparam int unsigned ADDR_W = 16;
`ifdef DATA_ACCESS_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic              req_word = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [15:0]       req_wdata = '0;
   logic              resp_valid;
   logic [15:0]       resp_rdata;
   logic              resp_err;
   logic              mem_write_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_data_in;
   logic [7:0]        mem_data_out;

   data_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          acc;
      int          lat;
      int          id;
   } exp_t;
   exp_t exp_q[$];
   int   next_id = 0;

   // data_memory model: byte-wide, synchronous write and one-cycle read latency
   logic [7:0] mem [0:65535];
   bit         corrupt_en = 1'b0;
   always @(posedge clk) begin
      if (mem_write_en)
         mem[mem_addr] <= (corrupt_en && mem_addr == 16'd7) ? ~mem_data_in[7:0] : mem_data_in[7:0];
      mem_data_out <= mem[mem_addr];
   end

   // Reference memory: what a correct unit leaves behind in data_memory
   logic [7:0] ref_mem [int];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every response and watches the memory port
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && mem_write_en) check("mem_data_in_upper", 64'(mem_data_in[15:8]), 64'd0);
      if (rst_n && !mem_write_en) check("mem_data_in_idle", 64'(mem_data_in), 64'd0);
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("rdata#%0d", e.id), 64'(resp_rdata), 64'(e.rdata));
            check($sformatf("err#%0d", e.id), 64'(resp_err), 64'(e.err));
            check($sformatf("latency#%0d", e.id), 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
   endfunction

   task automatic issue(input bit w, input bit wd, input logic [15:0] a, input logic [15:0] d,
                        input bit wait_resp);
      exp_t        e;
      int          budget;
      logic [15:0] a1;
      @(negedge clk);
      req_write = w; req_word = wd; req_addr = a; req_wdata = d; req_valid = 1'b1;
      budget = 0;
      while (!req_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
         req_valid = 1'b0;
         return;
      end
      a1 = a + 16'd1;
      e.acc = cyc;
      e.id  = next_id++;
      e.err = 1'b0;
      if (w) begin
         e.rdata = 16'h0000;
         e.lat   = RB ? (wd ? 7 : 4) : (wd ? 3 : 2);
         ref_mem[int'(a)] = (corrupt_en && a == 16'd7) ? ~d[7:0] : d[7:0];
         if (corrupt_en && a == 16'd7) e.err = RB;
         if (wd) begin
            ref_mem[int'(a1)] = (corrupt_en && a1 == 16'd7) ? ~d[15:8] : d[15:8];
            if (corrupt_en && a1 == 16'd7) e.err = RB;
         end
      end else begin
         e.rdata = wd ? {ref_rd(a1), ref_rd(a)} : {8'h00, ref_rd(a)};
         e.lat   = wd ? 5 : 3;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_word = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
      if (wait_resp) begin
         budget = 0;
         while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 50 cycles");
            exp_q.delete();
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", {12'd0, req_ready, resp_valid, resp_err, mem_write_en,
                                 resp_rdata, mem_addr, mem_data_in}, 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'(req_ready), 64'd1);

      issue(1'b1, 1'b0, 16'd2,  16'd25,  1'b1);
      issue(1'b1, 1'b0, 16'd5,  16'd50,  1'b1);
      issue(1'b1, 1'b0, 16'd10, 16'd250, 1'b1);
      issue(1'b0, 1'b0, 16'd2,  16'd0,   1'b1);
      issue(1'b0, 1'b0, 16'd5,  16'd0,   1'b1);
      issue(1'b0, 1'b0, 16'd10, 16'd0,   1'b1);

      issue(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1);
      check("word_mem_lo", 64'(mem[16'h0020]), 64'hEF);
      check("word_mem_hi", 64'(mem[16'h0021]), 64'hBE);
      issue(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1);

      issue(1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b1);
      check("wrap_mem_ffff", 64'(mem[16'hFFFF]), 64'h34);
      check("wrap_mem_0000", 64'(mem[16'h0000]), 64'h12);
      issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);

      // Abandon a word load during its first capture cycle
      issue(1'b0, 1'b1, 16'd2, 16'h0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_outputs", {60'd0, req_ready, resp_valid, mem_write_en, resp_err}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready", 64'(req_ready), 64'd1);
      repeat (6) @(negedge clk);
      issue(1'b0, 1'b0, 16'd2, 16'h0000, 1'b1);

`ifdef DATA_ACCESS_READBACK_EN
      corrupt_en = 1'b1;
      issue(1'b1, 1'b0, 16'd7, 16'h0055, 1'b1);
      issue(1'b1, 1'b0, 16'd8, 16'h0066, 1'b1);
      corrupt_en = 1'b0;
`endif

      for (int k = 0; k < 8; k++)
         issue(1'b1, 1'b1, 16'h0100 + 16'(2 * k), 16'($urandom), 1'b1);
      for (int k = 0; k < 40; k++)
         issue(1'($urandom), 1'($urandom), 16'h0100 + 16'($urandom_range(0, 14)),
               16'($urandom), 1'b1);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
